// File: rtl/decode_scan_n.sv
// decode_scan_n: registered AW-to-2^AW decoder/demultiplexer with
// active-low one-hot outputs and 74x138-style enables.
// Two modes: direct (address loaded on request) and scan (self-cycling
// through all addresses at a prescaled rate).
// Optional feature: define DECODE_SCAN_BLANK_EN to insert a one-cycle
// all-ones gap on y_n at every scan step (anti-ghosting).
module decode_scan_n #(
    parameter int unsigned AW       = 3,
    parameter int unsigned PRESCALE = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 e1_n,
    input  logic                 e2_n,
    input  logic                 e3,
    input  logic                 mode,
    input  logic                 load,
    input  logic [AW-1:0]        addr,
    output logic [(2**AW)-1:0]   y_n,
    output logic [AW-1:0]        cur_addr,
    output logic                 wrap
);

    localparam int unsigned NO = 2**AW;
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        DIS    = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [AW-1:0]   cur_addr_q, cur_addr_d;
    logic [NO-1:0]   y_n_q, y_n_d;
    logic            wrap_q, wrap_d;

    logic            en;
    logic            scanning;
    logic            scan_step;
    logic [NO-1:0]   one_hot;

    // Next-state, prescaler, address, wrap and decoded output computation.
    // y_n is decoded from the address the register takes at this same edge,
    // so y_n and cur_addr can never disagree.
    always_comb begin
        en = e3 & ~e1_n & ~e2_n;

        if (!en)
            state_d = DIS;
        else if (mode)
            state_d = SCAN;
        else
            state_d = DIRECT;

        // Only count while staying in SCAN; the entry edge merely clears.
        scanning  = (state_q == SCAN) && (state_d == SCAN);
        scan_step = scanning && (presc_q == PW'(PRESCALE - 1));

        presc_d    = presc_q;
        cur_addr_d = cur_addr_q;

        if ((state_d == SCAN) && (state_q != SCAN)) begin
            presc_d = '0;
        end else if (scanning) begin
            if (scan_step) begin
                presc_d    = '0;
                cur_addr_d = cur_addr_q + AW'(1);
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        // Direct loads apply even while disabled (preload while blanked).
        if (!mode && load)
            cur_addr_d = addr;

        wrap_d = scan_step && (cur_addr_q == '1);

        one_hot             = '0;
        one_hot[cur_addr_d] = 1'b1;

        y_n_d = en ? ~one_hot : '1;
`ifdef DECODE_SCAN_BLANK_EN
        if (scan_step)
            y_n_d = '1;
`else
`endif
    end

    // State register with synchronous reset dominating all inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DIS;
            presc_q    <= '0;
            cur_addr_q <= '0;
            y_n_q      <= '1;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            cur_addr_q <= cur_addr_d;
            y_n_q      <= y_n_d;
            wrap_q     <= wrap_d;
        end
    end

    assign y_n      = y_n_q;
    assign cur_addr = cur_addr_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_decode_scan_n.sv
// Directed self-checking bench for decode_scan_n (AW=3, PRESCALE=4).
// Expectations follow DECODE_SCAN_BLANK_EN when it is defined.
module tb_decode_scan_n;

    logic       clk;
    logic       reset;
    logic       e1_n;
    logic       e2_n;
    logic       e3;
    logic       mode;
    logic       load;
    logic [2:0] addr;
    logic [7:0] y_n;
    logic [2:0] cur_addr;
    logic       wrap;

    int checks;
    int failures;

`ifdef DECODE_SCAN_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    decode_scan_n #(.AW(3), .PRESCALE(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .e1_n     (e1_n),
        .e2_n     (e2_n),
        .e3       (e3),
        .mode     (mode),
        .load     (load),
        .addr     (addr),
        .y_n      (y_n),
        .cur_addr (cur_addr),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] dec(input logic [2:0] a);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << a);
    endfunction

    task automatic test_reset();
        reset = 1'b1; e1_n = 1'b1; e2_n = 1'b1; e3 = 1'b0;
        mode = 1'b0; load = 1'b0; addr = 3'd0;
        step(); step();
        checks++;
        if (y_n !== 8'hFF || cur_addr !== 3'd0 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset: y_n=%h cur=%0d wrap=%b expected y_n=ff cur=0 wrap=0", y_n, cur_addr, wrap);
        end
        reset = 1'b0;
    endtask

    task automatic test_direct_load();
        e1_n = 1'b0; e2_n = 1'b0; e3 = 1'b1; mode = 1'b0; load = 1'b1; addr = 3'd5;
        step();
        load = 1'b0; addr = 3'd1;
        checks++;
        if (y_n !== 8'hDF || cur_addr !== 3'd5 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL direct_load: y_n=%h cur=%0d wrap=%b expected y_n=df cur=5 wrap=0", y_n, cur_addr, wrap);
        end
        step();
        checks++;
        if (y_n !== 8'hDF || cur_addr !== 3'd5 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL direct_hold: y_n=%h cur=%0d wrap=%b expected y_n=df cur=5 wrap=0", y_n, cur_addr, wrap);
        end
    endtask

    task automatic test_enable_sweep();
        load = 1'b1; addr = 3'd2;
        step();
        load = 1'b0;
        checks++;
        if (y_n !== 8'hFB || cur_addr !== 3'd2) begin
            failures++;
            $display("FAIL sweep_load: y_n=%h cur=%0d expected y_n=fb cur=2", y_n, cur_addr);
        end
        for (int i = 0; i < 3; i++) begin
            e1_n = (i == 0); e2_n = (i == 1); e3 = (i != 2);
            step();
            checks++;
            if (y_n !== 8'hFF || cur_addr !== 3'd2 || wrap !== 1'b0) begin
                failures++;
                $display("FAIL sweep_off%0d: y_n=%h cur=%0d expected y_n=ff cur=2", i, y_n, cur_addr);
            end
            e1_n = 1'b0; e2_n = 1'b0; e3 = 1'b1;
            step();
            checks++;
            if (y_n !== 8'hFB || cur_addr !== 3'd2) begin
                failures++;
                $display("FAIL sweep_on%0d: y_n=%h cur=%0d expected y_n=fb cur=2", i, y_n, cur_addr);
            end
        end
        // Preload while blanked, then enable.
        e3 = 1'b0; load = 1'b1; addr = 3'd4;
        step();
        load = 1'b0;
        checks++;
        if (y_n !== 8'hFF || cur_addr !== 3'd4) begin
            failures++;
            $display("FAIL preload_blanked: y_n=%h cur=%0d expected y_n=ff cur=4", y_n, cur_addr);
        end
        e3 = 1'b1;
        step();
        checks++;
        if (y_n !== 8'hEF || cur_addr !== 3'd4) begin
            failures++;
            $display("FAIL preload_enable: y_n=%h cur=%0d expected y_n=ef cur=4", y_n, cur_addr);
        end
    endtask

    task automatic test_scan();
        logic [2:0] ea;
        logic [7:0] ey;
        logic       ew;
        mode = 1'b0; load = 1'b1; addr = 3'd6;
        step();
        // Load held high with a different address: scan must ignore it.
        mode = 1'b1; load = 1'b1; addr = 3'd0;
        for (int k = 0; k < 13; k++) begin
            step();
            ea = 3'(6 + k / 4);
            ew = (k == 8);
            ey = (BLANK && k > 0 && (k % 4) == 0) ? 8'hFF : dec(ea);
            checks++;
            if (cur_addr !== ea || y_n !== ey || wrap !== ew || $countones(~y_n) > 1) begin
                failures++;
                $display("FAIL scan k=%0d: cur=%0d y_n=%h wrap=%b expected cur=%0d y_n=%h wrap=%b",
                         k, cur_addr, y_n, wrap, ea, ey, ew);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_suspend();
        logic [2:0] ea;
        logic [7:0] ey;
        mode = 1'b0; load = 1'b1; addr = 3'd1;
        step();
        load = 1'b0; mode = 1'b1;
        for (int k = 0; k < 6; k++) step();   // step to 2 at k=4, prescaler at 1 after k=5
        e3 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (y_n !== 8'hFF || cur_addr !== 3'd2 || wrap !== 1'b0) begin
                failures++;
                $display("FAIL suspend k=%0d: y_n=%h cur=%0d wrap=%b expected y_n=ff cur=2 wrap=0", k, y_n, cur_addr, wrap);
            end
        end
        e3 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            ea = (k < 4) ? 3'd2 : 3'd3;
            ey = (BLANK && k == 4) ? 8'hFF : dec(ea);
            checks++;
            if (cur_addr !== ea || y_n !== ey || wrap !== 1'b0) begin
                failures++;
                $display("FAIL resume k=%0d: cur=%0d y_n=%h wrap=%b expected cur=%0d y_n=%h wrap=0",
                         k, cur_addr, y_n, wrap, ea, ey);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [2:0] ea;
        logic [7:0] ey;
        mode = 1'b0; load = 1'b1; addr = 3'd3;
        step();
        load = 1'b0; mode = 1'b1;
        step(); step();
        checks++;
        if (cur_addr !== 3'd3) begin
            failures++;
            $display("FAIL pre_reset_scan: cur=%0d expected cur=3", cur_addr);
        end
        reset = 1'b1;
        step();
        checks++;
        if (y_n !== 8'hFF || cur_addr !== 3'd0 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_scan: y_n=%h cur=%0d wrap=%b expected y_n=ff cur=0 wrap=0", y_n, cur_addr, wrap);
        end
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            ea = (k < 4) ? 3'd0 : 3'd1;
            ey = (BLANK && k == 4) ? 8'hFF : dec(ea);
            checks++;
            if (cur_addr !== ea || y_n !== ey || wrap !== 1'b0) begin
                failures++;
                $display("FAIL restart k=%0d: cur=%0d y_n=%h wrap=%b expected cur=%0d y_n=%h wrap=0",
                         k, cur_addr, y_n, wrap, ea, ey);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_direct_load();
        test_enable_sweep();
        test_scan();
        test_suspend();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_scan_n.md
Name: decode_scan_n

Overview:
- Registered, parametrised AW-to-2^AW decoder/demultiplexer with active-low one-hot outputs and 74x138-style enables (two active-low, one active-high).
- Two modes:
  - direct: an address is loaded on request.
  - scan: the block cycles through all addresses itself at a prescaled rate.
- Sits between control logic and multiplexed loads (display digit selects, chip selects, row strobes). Replaces combinational decoders where glitch-free, clocked selects are needed.

Parameters:
- AW, 3: address width; output width is 2^AW.
- PRESCALE, 4: clock cycles per scan step; legal range 1..65535.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- e1_n  input  1  enable, active low.
- e2_n  input  1  enable, active low.
- e3  input  1  enable, active high.
- mode  input  1  0 = direct, 1 = scan.
- load  input  1  direct mode: capture addr this cycle.
- addr  input  AW  direct-mode address.
- y_n  output  2^AW  registered decoded outputs, active low, at most one bit low.
- cur_addr  output  AW  registered address currently selected.
- wrap  output  1  one-cycle pulse when the scan rolls over from 2^AW-1 to 0.

Behaviour:
- Enable: en = e3 & ~e1_n & ~e2_n, evaluated every cycle.
- Reset (while reset=1 at an edge):
  - y_n = all ones, cur_addr = 0, wrap = 0.
  - Prescaler = 0, state = DIS.
  - Reset dominates all other inputs, including mid-scan.
- State machine (next state chosen each edge, reset excluded):
  - DIS when en=0.
  - DIRECT when en=1 and mode=0.
  - SCAN when en=1 and mode=1.
- cur_addr update:
  - mode=0 and load=1: cur_addr <= addr. This applies regardless of en, so a new address can be preloaded while blanked.
  - mode=0 and load=0: cur_addr holds.
  - SCAN: prescaler counts 0..PRESCALE-1. On the edge where the prescaler equals PRESCALE-1:
    - prescaler <= 0
    - cur_addr <= cur_addr+1, modulo 2^AW
  - SCAN with PRESCALE=1: cur_addr steps every cycle.
  - SCAN ignores load.
  - DIS: cur_addr and prescaler freeze, except for direct loads as stated above.
- Mode and enable transitions:
  - Entering SCAN from DIRECT or DIS clears the prescaler. Scanning begins from the present cur_addr, and the first step occurs PRESCALE cycles after entry.
  - Leaving SCAN leaves cur_addr unchanged.
- wrap:
  - wrap <= 1 on exactly the edge where SCAN steps cur_addr from 2^AW-1 to 0; otherwise wrap <= 0.
  - wrap is never asserted in DIRECT or DIS.
- Output:
  - y_n <= en ? ~(1 << cur_addr_next) : all ones, where cur_addr_next is the value cur_addr takes at the same edge.
  - y_n and cur_addr are therefore always mutually consistent.
  - Latency from the load/addr sample, or an enable change, to y_n: one clock.
- Width rules:
  - Prescaler width = clog2(PRESCALE), minimum 1.
  - Address arithmetic is unsigned and wraps naturally at AW bits.
- Invariant: y_n never has more than one bit low in any cycle.

Optional Feature:
- Macro: DECODE_SCAN_BLANK_EN.
- Defined (anti-ghosting gap):
  - On every SCAN step edge, y_n <= all ones for that one cycle while cur_addr advances.
  - The next cycle shows the new selection.
  - Each address is therefore low for PRESCALE-1 of every PRESCALE cycles.
  - With PRESCALE=1, y_n stays all ones in SCAN.
  - DIRECT-mode loads are not blanked.
- Undefined: no gap; y_n switches directly between adjacent selections.

Test Plan:
1. Reset, then enables e1_n=0, e2_n=0, e3=1, mode=0, load=1, addr=5 for one cycle → after the next edge cur_addr=5, y_n=8'b1101_1111; wrap=0 throughout.
2. Enable sweep with addr=2 loaded: each of e1_n=1, e2_n=1, e3=0 in turn → y_n=8'hFF one cycle after the change; cur_addr stays 2; restoring enables gives y_n=8'hFB one cycle later.
3. SCAN with PRESCALE=4 from cur_addr=6 → cur_addr=6 for 4 cycles, then 7 for 4 cycles, then 0 with wrap=1 for exactly one cycle, then 1 after 4 more cycles; y_n stays one-hot consistent with cur_addr.
4. Mid-scan, drop e3 for 3 cycles → y_n=8'hFF and cur_addr/prescaler frozen; on re-enable the scan resumes from the same address, with a full PRESCALE dwell before the next step (prescaler cleared on entry).
5. Reset asserted during SCAN at cur_addr=3 → next edge: y_n=8'hFF, cur_addr=0, wrap=0; after release, SCAN restarts from 0.
6. With DECODE_SCAN_BLANK_EN defined, PRESCALE=4: per address, 3 cycles one-hot plus 1 cycle 8'hFF at each step edge; without the macro, 4 contiguous one-hot cycles and no all-ones cycle.
